// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, HALT opcode and fetch state encoding
package cpu_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 16;
  localparam int IF_W = 24;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic {RUN, HALTED} state_e;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: 256x16 instruction store, sync write, async (read-first) read
module instr_mem
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PC_W-1:0]    raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);
  logic [INSTR_W-1:0] mem_q [2**PC_W];
  // program load port; contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, branch redirect, stall hold and HALT stop
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [IF_W-1:0]    IF_output,
  output logic               if_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);
  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [IF_W-1:0]    out_q, out_d;
  logic               valid_q, valid_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr;

  instr_mem u_mem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (imem_waddr),
    .wdata_i (imem_wdata),
    .raddr_i (pc_q),
    .rdata_o (instr)
  );

  // next state: branch beats stall, stall beats HALTED, else fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      state_d = RUN;
      pc_d    = branch_target;
      out_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == HALTED) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else begin
      out_d   = {instr, pc_q};
      valid_d = 1'b1;
      cnt_d   = cnt_q + 16'd1;
      state_d = (instr[3:0] == OP_HALT) ? HALTED : RUN;
      pc_d    = (instr[3:0] == OP_HALT) ? pc_q : pc_q + 1'b1;
    end
  end

  // stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IF_output   = out_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table vectors, corner sequences and random run against a reference model
module tb_instruction_fetch;
  logic        clk = 0;
  logic        reset, stall, branch_taken, imem_we;
  logic [7:0]  branch_target, imem_waddr;
  logic [15:0] imem_wdata;
  logic [23:0] IF_output;
  logic        if_valid, halted;
  logic [15:0] fetch_count;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .IF_output     (IF_output),
    .if_valid      (if_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  // reference model: program image plus architectural fetch state
  logic [15:0] m_mem [256];
  logic [7:0]  m_pc;
  logic [23:0] m_out;
  logic        m_v, m_h;
  logic [15:0] m_cnt;

  typedef struct {
    logic        r, s, b;
    logic [7:0]  t;
    logic [23:0] out;
    logic        v, h;
    logic [15:0] c;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_model(input string nm);
    chk(nm, {22'b0, IF_output, if_valid, halted, fetch_count},
            {22'b0, m_out, m_v, m_h, m_cnt});
  endtask

  task automatic drive(input logic r, s, b, input logic [7:0] t,
                       input logic we, input logic [7:0] wa, input logic [15:0] wd);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
  endtask

  task automatic model_step();
    logic [15:0] ins;
    ins = m_mem[m_pc];
    if (reset) begin
      m_pc = 0; m_out = 0; m_v = 0; m_h = 0; m_cnt = 0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_out = 0; m_v = 0; m_h = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_h) begin
      m_out = 0; m_v = 0;
    end else begin
      m_out = {ins, m_pc}; m_v = 1; m_cnt = m_cnt + 1;
      if (ins[3:0] == 4'hF) m_h = 1;
      else m_pc = m_pc + 1;
    end
    if (imem_we) m_mem[imem_waddr] = imem_wdata;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    drive(1, 0, 0, 0, 1, a, d);
    cyc();
  endtask

  initial begin
    m_pc = 0; m_out = 0; m_v = 0; m_h = 0; m_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) load(i[7:0], 16'h0000);
    load(8'h00, 16'h1230);
    load(8'h01, 16'h4561);
    load(8'h02, 16'h789F);
    load(8'h40, 16'hABC2);

    tv[0]  = '{1, 0, 0, 8'h00, 24'h000000, 0, 0, 16'd0};
    tv[1]  = '{0, 0, 0, 8'h00, 24'h123000, 1, 0, 16'd1};
    tv[2]  = '{0, 1, 0, 8'h00, 24'h123000, 1, 0, 16'd1};
    tv[3]  = '{0, 1, 0, 8'h00, 24'h123000, 1, 0, 16'd1};
    tv[4]  = '{0, 1, 0, 8'h00, 24'h123000, 1, 0, 16'd1};
    tv[5]  = '{0, 0, 0, 8'h00, 24'h456101, 1, 0, 16'd2};
    tv[6]  = '{0, 0, 0, 8'h00, 24'h789F02, 1, 1, 16'd3};
    tv[7]  = '{0, 0, 0, 8'h00, 24'h000000, 0, 1, 16'd3};
    tv[8]  = '{0, 1, 1, 8'h40, 24'h000000, 0, 0, 16'd3};
    tv[9]  = '{0, 0, 0, 8'h00, 24'hABC240, 1, 0, 16'd4};
    tv[10] = '{1, 0, 0, 8'h00, 24'h000000, 0, 0, 16'd0};
    tv[11] = '{0, 0, 0, 8'h00, 24'h123000, 1, 0, 16'd1};
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].r, tv[i].s, tv[i].b, tv[i].t, 0, 0, 0);
      cyc();
      chk($sformatf("vec%0d", i), {22'b0, IF_output, if_valid, halted, fetch_count},
          {22'b0, tv[i].out, tv[i].v, tv[i].h, tv[i].c});
    end

    drive(0, 0, 1, 8'h40, 0, 0, 0);
    cyc();
    chk("branch_bubble", {IF_output, if_valid}, {24'h0, 1'b0});
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("branch_target_fetch", {IF_output, if_valid}, {24'hABC240, 1'b1});

    for (int i = 0; i < 256; i++) load(i[7:0], {i[7:0], 8'h01});
    drive(0, 0, 1, 8'hFE, 0, 0, 0);
    cyc();
    chk_model("wrap_bubble");
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("wrap_fe", IF_output, 24'hFE01FE);
    cyc();
    chk("wrap_ff", IF_output, 24'hFF01FF);
    cyc();
    chk("wrap_00", IF_output, 24'h000100);

    load(8'h00, 16'h0011);
    load(8'h01, 16'h0021);
    load(8'h02, 16'h0031);
    load(8'h03, 16'h0041);
    load(8'h04, 16'h005F);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("halt_count5", {halted, if_valid, fetch_count}, {1'b1, 1'b0, 16'd5});
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("reset_from_halt", {22'b0, IF_output, if_valid, halted, fetch_count}, 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("restart_pc0", {IF_output, if_valid, fetch_count}, {24'h001100, 1'b1, 16'd1});
    cyc();
    chk("mem_kept", IF_output, 24'h002101);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
            8'($urandom), 16'($urandom));
      cyc();
      chk_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, port reset.
REQ-002 Port: clk  in  1  stage clock, all state updates on posedge.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: stall  in  1  hold request from operand fetch; freezes PC and IF_output.
REQ-005 Port: branch_taken  in  1  redirect request from execute.
REQ-006 Port: branch_target  in  8  redirect PC.
REQ-007 Port: imem_we  in  1  instruction-memory write enable (program load).
REQ-008 Port: imem_waddr  in  8  write address.
REQ-009 Port: imem_wdata  in  16  write data.
REQ-010 Port: IF_output  out  24  {instruction[15:0], pc[7:0]}; opcode at [11:8], reg1 [15:12], reg2 [19:16], dest [23:20], address [23:16].
REQ-011 Port: if_valid  out  1  IF_output holds a real instruction.
REQ-012 Port: halted  out  1  fetch stopped on HALT.
REQ-013 Port: fetch_count  out  16  number of valid instructions issued.

Function
REQ-014 SHALL hold internal 256x16 instruction memory; write at posedge when imem_we=1; not reset.
REQ-015 Same-cycle read and write to one address SHALL return old data (read-first).
REQ-016 States SHALL be RUN and HALTED; reset enters RUN.
REQ-017 RUN, no stall, no branch: IF_output <= {imem[pc], pc}, if_valid <= 1, pc <= pc+1, fetch_count += 1; one-cycle latency from PC to IF_output.
REQ-018 PC increment SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-019 stall=1 (no branch): pc, IF_output, if_valid, fetch_count, state SHALL hold.
REQ-020 branch_taken=1: pc <= branch_target, IF_output <= 24'h0, if_valid <= 0 (bubble), state <= RUN; overrides stall and HALTED.
REQ-021 Priority SHALL be reset > branch_taken > stall > HALT > normal fetch.
REQ-022 Fetched opcode (instruction[3:0]) == OP_HALT (4'hF): issue it with if_valid=1, count it, pc holds, state <= HALTED.
REQ-023 HALTED without branch: if_valid <= 0, IF_output <= 24'h0, pc and fetch_count hold, halted=1.
REQ-024 halted SHALL equal (state == HALTED), combinational from state.
REQ-025 fetch_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-026 Branch and stall in the same cycle: branch wins; stall ignored that cycle.

Reset
REQ-027 On reset: pc=8'h00, IF_output=24'h0, if_valid=0, fetch_count=0, state=RUN, halted=0.
REQ-028 Reset mid-stall or mid-HALTED SHALL return to RUN; first fetch (address 0) appears on the first posedge with reset low.
REQ-029 Reset SHALL NOT alter memory contents.

Structure
REQ-030 Shared package cpu_pkg SHALL hold PC_W=8, INSTR_W=16, IF_W=24, OP_HALT=4'hF, state enum.
REQ-031 Memory SHALL be sub-module instr_mem (256x16, one sync write port, async read port).
REQ-032 IF_output field layout SHALL match the operand-fetch stage input exactly.

Verification
REQ-033 Load imem[0..2]=16'h1230,16'h4561,16'h789F; release reset -> IF_output 24'h123000, 24'h456101, 24'h789F02 on consecutive cycles, valid=1, then halted=1, valid=0, fetch_count=3.
REQ-034 Stall held 3 cycles after first fetch -> IF_output stays 24'h123000, pc stays 1, fetch_count stays 1; release -> 24'h456101 next cycle.
REQ-035 branch_taken=1, target=8'h40, imem[0x40]=16'hABC2 -> next cycle valid=0, IF_output=0; cycle after -> 24'hABC240.
REQ-036 Branch+stall same cycle, and branch while HALTED -> redirect taken, state RUN, halted=0.
REQ-037 Fill all non-HALT, branch to 8'hFE -> PCs FE, FF, 00 issued in order.
REQ-038 Assert reset while HALTED with fetch_count=5 -> outputs all zero next cycle, fetch restarts at pc 0, memory unchanged.
